// File: rtl/datapath_exec.sv
// Execution datapath: 8x4 register file, 16x4 data memory with synchronous
// read, 4-bit ALU and an IDLE/EX/WB sequencer driven by a latched control word.
module datapath_exec #(
   parameter int DW       = 4,
   parameter int RF_DEPTH = 8,
   parameter int DM_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        exec_en,
   input  logic [$clog2(DM_DEPTH)-1:0] D_addr,
   input  logic                        D_rd,
   input  logic                        D_wr,
   input  logic [$clog2(RF_DEPTH)-1:0] RF_addr1,
   input  logic [$clog2(RF_DEPTH)-1:0] RF_addr2,
   input  logic [$clog2(RF_DEPTH)-1:0] RF_waddr,
   input  logic [1:0]                  ALUSel,
   input  logic                        isExternal,
   input  logic                        wr_en,
   input  logic [DW-1:0]               ext_data,
   input  logic [$clog2(RF_DEPTH)-1:0] dbg_addr,
   output logic                        busy,
   output logic                        done,
   output logic [DW-1:0]               result,
   output logic                        zero,
   output logic                        carry,
   output logic                        err,
   output logic [DW-1:0]               dbg_data
);
   localparam int RA = $clog2(RF_DEPTH);
   localparam int MA = $clog2(DM_DEPTH);

   typedef enum logic [1:0] {IDLE, EX, WB} state_t;

   state_t          state_q;
   logic [DW-1:0]   rf_q [RF_DEPTH];
   logic [DW-1:0]   dm_q [DM_DEPTH];

   // latched control word: later input changes cannot disturb the instruction
   logic [MA-1:0]   d_addr_q;
   logic            d_rd_q, d_wr_q, ext_q, wr_en_q;
   logic [RA-1:0]   a1_q, a2_q, wa_q;
   logic [1:0]      sel_q;
   logic [DW-1:0]   ext_data_q;

   logic [DW-1:0]   mdr_q, alu_q, result_q;
   logic            done_q, zero_q, carry_q, err_q;

   logic [DW-1:0]   op_a, op_b, alu_d, store_d, wb_d;
   logic            carry_d;
   logic [DW:0]     sum_w, diff_w;

   // ALU and operand selection on the latched control word
   always_comb begin
      op_a    = rf_q[a1_q];
      op_b    = rf_q[a2_q];
      sum_w   = {1'b0, op_a} + {1'b0, op_b};
      diff_w  = {1'b0, op_a} - {1'b0, op_b};
      alu_d   = '0;
      carry_d = 1'b0;
      case (sel_q)
         2'b00: begin alu_d = sum_w[DW-1:0];  carry_d = sum_w[DW];  end
         2'b01: begin alu_d = diff_w[DW-1:0]; carry_d = diff_w[DW]; end  // top bit = borrow
         2'b10: alu_d = op_a & op_b;
         default: alu_d = op_a | op_b;
      endcase
      store_d = ext_q ? ext_data_q : op_a;
      // only loads and ALU ops reach WB; d_rd tells them apart
      wb_d    = d_rd_q ? mdr_q : alu_q;
   end

   // sequencer, storage and flags; decode priority is illegal > store > load > ALU > NOP
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         done_q     <= 1'b0;
         result_q   <= '0;
         zero_q     <= 1'b0;
         carry_q    <= 1'b0;
         err_q      <= 1'b0;
         mdr_q      <= '0;
         alu_q      <= '0;
         d_addr_q   <= '0;
         d_rd_q     <= 1'b0;
         d_wr_q     <= 1'b0;
         ext_q      <= 1'b0;
         wr_en_q    <= 1'b0;
         a1_q       <= '0;
         a2_q       <= '0;
         wa_q       <= '0;
         sel_q      <= '0;
         ext_data_q <= '0;
         for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
         for (int i = 0; i < DM_DEPTH; i++) dm_q[i] <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (exec_en) begin
               d_addr_q   <= D_addr;
               d_rd_q     <= D_rd;
               d_wr_q     <= D_wr;
               ext_q      <= isExternal;
               wr_en_q    <= wr_en;
               a1_q       <= RF_addr1;
               a2_q       <= RF_addr2;
               wa_q       <= RF_waddr;
               sel_q      <= ALUSel;
               ext_data_q <= ext_data;
               state_q    <= EX;
            end
            EX: begin
               if (d_rd_q && d_wr_q) begin
                  err_q   <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end else if (d_wr_q) begin
                  dm_q[d_addr_q] <= store_d;
                  result_q       <= store_d;
                  done_q         <= 1'b1;
                  state_q        <= IDLE;
               end else if (d_rd_q && wr_en_q) begin
                  mdr_q   <= ext_q ? ext_data_q : dm_q[d_addr_q];
                  state_q <= WB;
               end else if (wr_en_q) begin
                  alu_q   <= alu_d;
                  zero_q  <= (alu_d == '0);
                  carry_q <= carry_d;
                  state_q <= WB;
               end else begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
            WB: begin
               rf_q[wa_q] <= wb_d;
               result_q   <= wb_d;
               done_q     <= 1'b1;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign result   = result_q;
   assign zero     = zero_q;
   assign carry    = carry_q;
   assign err      = err_q;
   assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_datapath_exec.sv
// Bench for datapath_exec: directed table, hand-written corner sequences and
// random instructions checked against an arithmetic reference model.
module tb_datapath_exec;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       exec_en = 1'b0;
   logic [3:0] D_addr = '0;
   logic       D_rd = 1'b0, D_wr = 1'b0;
   logic [2:0] RF_addr1 = '0, RF_addr2 = '0, RF_waddr = '0;
   logic [1:0] ALUSel = '0;
   logic       isExternal = 1'b0, wr_en = 1'b0;
   logic [3:0] ext_data = '0;
   logic [2:0] dbg_addr = '0;
   logic       busy, done, zero, carry, err;
   logic [3:0] result, dbg_data;

   datapath_exec dut (
      .clk(clk), .reset(reset), .exec_en(exec_en), .D_addr(D_addr), .D_rd(D_rd),
      .D_wr(D_wr), .RF_addr1(RF_addr1), .RF_addr2(RF_addr2), .RF_waddr(RF_waddr),
      .ALUSel(ALUSel), .isExternal(isExternal), .wr_en(wr_en), .ext_data(ext_data),
      .dbg_addr(dbg_addr), .busy(busy), .done(done), .result(result), .zero(zero),
      .carry(carry), .err(err), .dbg_data(dbg_data)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic [3:0] daddr;
      logic       rd, wr;
      logic [2:0] a1, a2, wa;
      logic [1:0] sel;
      logic       ext, we;
      logic [3:0] xd;
      int         lat;
      logic [3:0] res;
      logic       z, c, e;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int m_rf[8];
   int m_dm[16];
   int m_res, m_z, m_c, m_e;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] daddr, input logic rd, input logic wr,
                               input logic [2:0] a1, input logic [2:0] a2, input logic [2:0] wa,
                               input logic [1:0] sel, input logic ext, input logic we,
                               input logic [3:0] xd, input int lat, input logic [3:0] res,
                               input logic z, input logic c, input logic e);
      vec_t v;
      v.daddr = daddr; v.rd = rd; v.wr = wr; v.a1 = a1; v.a2 = a2; v.wa = wa;
      v.sel = sel; v.ext = ext; v.we = we; v.xd = xd; v.lat = lat; v.res = res;
      v.z = z; v.c = c; v.e = e;
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_rf[i] = 0;
      for (int i = 0; i < 16; i++) m_dm[i] = 0;
      m_res = 0; m_z = 0; m_c = 0; m_e = 0;
   endtask

   // applies one instruction to the model, returns expected done latency
   task automatic model_apply(input vec_t v, output int lat);
      int a, b, val;
      a = m_rf[v.a1];
      b = m_rf[v.a2];
      if (v.rd && v.wr) begin
         m_e = 1; lat = 2;
      end else if (v.wr) begin
         val = v.ext ? int'(v.xd) : a;
         m_dm[v.daddr] = val; m_res = val; lat = 2;
      end else if (v.rd && v.we) begin
         val = v.ext ? int'(v.xd) : m_dm[v.daddr];
         m_rf[v.wa] = val; m_res = val; lat = 3;
      end else if (v.we) begin
         case (v.sel)
            2'd0: begin val = (a + b) % 16; m_c = (a + b >= 16) ? 1 : 0; end
            2'd1: begin val = (a - b + 16) % 16; m_c = (a < b) ? 1 : 0; end
            2'd2: begin val = a & b; m_c = 0; end
            default: begin val = a | b; m_c = 0; end
         endcase
         m_z = (val == 0) ? 1 : 0;
         m_rf[v.wa] = val; m_res = val; lat = 3;
      end else begin
         lat = 2;
      end
   endtask

   task automatic drive(input vec_t v);
      D_addr = v.daddr; D_rd = v.rd; D_wr = v.wr; RF_addr1 = v.a1; RF_addr2 = v.a2;
      RF_waddr = v.wa; ALUSel = v.sel; isExternal = v.ext; wr_en = v.we; ext_data = v.xd;
   endtask

   task automatic scramble();
      D_addr = 4'($urandom); D_rd = 1'($urandom); D_wr = 1'($urandom);
      RF_addr1 = 3'($urandom); RF_addr2 = 3'($urandom); RF_waddr = 3'($urandom);
      ALUSel = 2'($urandom); isExternal = 1'($urandom); wr_en = 1'($urandom);
      ext_data = 4'($urandom);
   endtask

   // strobe one instruction, then scramble inputs and count cycles to done
   task automatic run(input vec_t v, output int lat);
      bit busy_ok;
      @(negedge clk);
      drive(v);
      exec_en = 1'b1;
      @(posedge clk);
      #1 exec_en = 1'b0;
      scramble();
      lat = 0;
      busy_ok = 1;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (done) begin lat = n; break; end
         if (!busy) busy_ok = 0;
      end
      check("busy_in_flight", int'(busy_ok), 1);
      check("busy_at_done", int'(busy), 0);
   endtask

   task automatic check_rf(input string name);
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1 check(name, int'(dbg_data), m_rf[i]);
      end
   endtask

   vec_t tbl[15];
   vec_t v, v2;
   int   lat, mlat;

   initial begin
      model_reset();
      // directed program: expected outputs worked out by hand
      tbl[0]  = mk(4'd0, 1, 0, 3'd0, 3'd0, 3'd3, 2'd0, 1, 1, 4'hA, 3, 4'hA, 0, 0, 0);
      tbl[1]  = mk(4'd5, 0, 1, 3'd3, 3'd0, 3'd0, 2'd0, 0, 0, 4'h0, 2, 4'hA, 0, 0, 0);
      tbl[2]  = mk(4'd5, 1, 0, 3'd0, 3'd0, 3'd6, 2'd0, 0, 1, 4'h0, 3, 4'hA, 0, 0, 0);
      tbl[3]  = mk(4'd0, 1, 0, 3'd0, 3'd0, 3'd1, 2'd0, 1, 1, 4'h9, 3, 4'h9, 0, 0, 0);
      tbl[4]  = mk(4'd0, 1, 0, 3'd0, 3'd0, 3'd2, 2'd0, 1, 1, 4'h8, 3, 4'h8, 0, 0, 0);
      tbl[5]  = mk(4'd0, 0, 0, 3'd1, 3'd2, 3'd7, 2'd0, 0, 1, 4'h0, 3, 4'h1, 0, 1, 0);
      tbl[6]  = mk(4'd0, 0, 0, 3'd1, 3'd2, 3'd4, 2'd1, 0, 1, 4'h0, 3, 4'h1, 0, 0, 0);
      tbl[7]  = mk(4'd0, 0, 0, 3'd2, 3'd1, 3'd5, 2'd1, 0, 1, 4'h0, 3, 4'hF, 0, 1, 0);
      tbl[8]  = mk(4'd0, 1, 0, 3'd0, 3'd0, 3'd2, 2'd0, 1, 1, 4'h6, 3, 4'h6, 0, 1, 0);
      tbl[9]  = mk(4'd0, 0, 0, 3'd1, 3'd2, 3'd0, 2'd2, 0, 1, 4'h0, 3, 4'h0, 1, 0, 0);
      tbl[10] = mk(4'd5, 1, 1, 3'd0, 3'd0, 3'd3, 2'd0, 1, 1, 4'hF, 2, 4'h0, 1, 0, 1);
      tbl[11] = mk(4'd7, 0, 1, 3'd0, 3'd0, 3'd0, 2'd0, 1, 0, 4'hC, 2, 4'hC, 1, 0, 1);
      tbl[12] = mk(4'd0, 0, 0, 3'd3, 3'd1, 3'd7, 2'd3, 0, 1, 4'h0, 3, 4'hB, 0, 0, 1);
      tbl[13] = mk(4'd5, 1, 0, 3'd0, 3'd0, 3'd1, 2'd0, 0, 1, 4'h0, 3, 4'hA, 0, 0, 1);
      tbl[14] = mk(4'd0, 0, 0, 3'd0, 3'd0, 3'd0, 2'd0, 0, 0, 4'h0, 2, 4'hA, 0, 0, 1);

      // reset state
      #15;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_result", int'(result), 0);
      check("rst_flags", int'({zero, carry, err}), 0);
      check_rf("rst_rf");
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 15; i++) begin
         run(tbl[i], lat);
         model_apply(tbl[i], mlat);
         check($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
         check($sformatf("tbl%0d_result", i), int'(result), int'(tbl[i].res));
         check($sformatf("tbl%0d_zero", i), int'(zero), int'(tbl[i].z));
         check($sformatf("tbl%0d_carry", i), int'(carry), int'(tbl[i].c));
         check($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].e));
         check_rf($sformatf("tbl%0d_rf", i));
      end

      // second strobe one cycle after a load start must be ignored
      reset = 1'b1;
      #1 model_reset();
      @(negedge clk);
      reset = 1'b0;
      v  = mk(4'd0, 1, 0, 3'd0, 3'd0, 3'd2, 2'd0, 1, 1, 4'h5, 3, 4'h5, 0, 0, 0);
      v2 = mk(4'd0, 1, 0, 3'd0, 3'd0, 3'd4, 2'd0, 1, 1, 4'h7, 3, 4'h7, 0, 0, 0);
      @(negedge clk);
      drive(v);
      exec_en = 1'b1;
      @(posedge clk);
      #1 drive(v2);
      @(posedge clk);
      #1 exec_en = 1'b0;
      lat = 0;
      for (int n = 2; n <= 8; n++) begin
         @(negedge clk);
         if (done) begin lat = n; break; end
      end
      model_apply(v, mlat);
      check("dbl_lat", lat, mlat);
      check("dbl_result", int'(result), 5);
      mlat = 0;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         if (done || busy) mlat++;
      end
      check("dbl_no_second", mlat, 0);
      check_rf("dbl_rf");

      // reset during the WB cycle of an ALU op aborts the write
      v = mk(4'd0, 1, 0, 3'd0, 3'd0, 3'd1, 2'd0, 1, 1, 4'h3, 3, 4'h3, 0, 0, 0);
      run(v, lat);
      model_apply(v, mlat);
      v = mk(4'd0, 0, 0, 3'd1, 3'd1, 3'd5, 2'd0, 0, 1, 4'h0, 3, 4'h6, 0, 0, 0);
      @(negedge clk);
      drive(v);
      exec_en = 1'b1;
      @(posedge clk);
      #1 exec_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rstwb_busy_before", int'(busy), 1);
      reset = 1'b1;
      #1;
      check("rstwb_busy", int'(busy), 0);
      check("rstwb_done", int'(done), 0);
      model_reset();
      check_rf("rstwb_rf");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rstwb_done_after", int'(done), 0);
      check("rstwb_result", int'(result), 0);

      // random instructions against the model
      for (int i = 0; i < 60; i++) begin
         v.daddr = 4'($urandom); v.rd = 1'($urandom); v.wr = ($urandom_range(0, 3) == 0);
         v.a1 = 3'($urandom); v.a2 = 3'($urandom); v.wa = 3'($urandom);
         v.sel = 2'($urandom); v.ext = 1'($urandom); v.we = ($urandom_range(0, 4) != 0);
         v.xd = 4'($urandom);
         if (i < 40 && v.rd && v.wr) v.wr = 1'b0;
         run(v, lat);
         model_apply(v, mlat);
         check("rnd_lat", lat, mlat);
         check("rnd_result", int'(result), m_res);
         check("rnd_zero", int'(zero), m_z);
         check("rnd_carry", int'(carry), m_c);
         check("rnd_err", int'(err), m_e);
         check_rf("rnd_rf");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
